// File: rtl/self_pkg.sv
// Shared codes for the player-ship renderer: handshake states, op codes, colours, FSM states.
package self_pkg;
  localparam int SCREEN_W = 160;

  typedef enum logic [3:0] {
    SELF_BUSY       = 4'd0,
    SELF_READY      = 4'd1,
    SELF_NEED_ERASE = 4'd2
  } self_state_e;

  typedef enum logic [1:0] {
    OP_DRAW  = 2'b00,
    OP_ERASE = 2'b01,
    OP_FIRE  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [2:0] COL_SHIP   = 3'b010;
  localparam logic [2:0] COL_BULLET = 3'b100;
  localparam logic [2:0] COL_BG     = 3'b000;

  typedef enum logic [2:0] {
    ST_READY,
    ST_DRAW_SHIP,
    ST_DRAW_BULLET,
    ST_HOLD,
    ST_NEED_ERASE,
    ST_ERASE_SHIP,
    ST_ERASE_BULLET
  } fsm_e;

  function automatic logic [3:0] state_code(input fsm_e s);
    case (s)
      ST_READY:      return SELF_READY;
      ST_NEED_ERASE: return SELF_NEED_ERASE;
      default:       return SELF_BUSY;
    endcase
  endfunction
endpackage

// File: rtl/self_render_rect_scanner.sv
// Raster scanner: one registered pixel coordinate per cycle over a width x height box,
// rows advancing down or (up=1) upward from the origin; start restarts from the origin.
module rect_scanner #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          up,
  input  logic [XW-1:0] org_x,
  input  logic [YW-1:0] org_y,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [XW-1:0] px,
  output logic [YW-1:0] py,
  output logic          valid,
  output logic          last
);
  logic [XW-1:0] cx_q, cx_d, px_q, px_d;
  logic [YW-1:0] cy_q, cy_d, py_q, py_d;
  logic          valid_q, valid_d, last_q, last_d;

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    if (start) begin
      cx_d    = '0;
      cy_d    = '0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      if (last_q) begin
        valid_d = 1'b0;
      end else if (cx_q == width - XW'(1)) begin
        cx_d = '0;
        cy_d = cy_q + YW'(1);
      end else begin
        cx_d = cx_q + XW'(1);
      end
    end
    px_d   = org_x + cx_d;
    py_d   = up ? (org_y - cy_d) : (org_y + cy_d);
    // registered so the caller may pick the next box's dimensions from last without a loop
    last_d = valid_d && (cx_d == width - XW'(1)) && (cy_d == height - YW'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cx_q    <= '0;
      cy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign px    = px_q;
  assign py    = py_q;
  assign valid = valid_q;
  assign last  = last_q;
endmodule

// File: rtl/self_render.sv
// Player-ship renderer: draws/fires/erases the ship and bullet column one pixel per cycle,
// then holds the image for HOLD_CYCLES before asking control for an erase.
module self_render
  import self_pkg::*;
#(
  parameter int SHIP_W      = 10,
  parameter int SHIP_H      = 4,
  parameter int SHIP_Y      = 110,
  parameter int BULLET_H    = 100,
  parameter int HOLD_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       self_enable,
  input  logic [1:0] op,
  input  logic [7:0] x,
  output logic [3:0] self_state,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);
  localparam logic [7:0] X_MAX = 8'(SCREEN_W - SHIP_W);
  localparam int         HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  generate
    if (SHIP_Y < BULLET_H) begin : g_bullet_fits
      $error("bullet column would run above row 0");
    end
  endgenerate

  fsm_e          state_q, state_d;
  logic [7:0]    x_l_q, x_l_d;
  logic          fired_q, fired_d, done_q, done_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    colour_q, colour_d;

  logic       scan_start, scan_valid, scan_last, sel_bullet;
  logic       accept, start_erase, to_bullet, seq_end, ship_st, bullet_st, erase_ctx;
  logic [7:0] x_clamp, org_x, scan_w, scan_px;
  logic [6:0] org_y, scan_h, scan_py;

  assign x_clamp     = (x > X_MAX) ? X_MAX : x;
  assign accept      = (state_q == ST_READY) && self_enable && (op == OP_DRAW || op == OP_FIRE);
  assign start_erase = (state_q == ST_NEED_ERASE) && self_enable && (op == OP_ERASE);
  assign ship_st     = (state_q == ST_DRAW_SHIP) || (state_q == ST_ERASE_SHIP);
  assign bullet_st   = (state_q == ST_DRAW_BULLET) || (state_q == ST_ERASE_BULLET);
  assign erase_ctx   = (state_q == ST_NEED_ERASE) || (state_q == ST_ERASE_SHIP) ||
                       (state_q == ST_ERASE_BULLET);
  // the bullet scan starts on the ship's last pixel so the two runs are back to back
  assign to_bullet   = ship_st && scan_last && fired_q;
  assign seq_end     = scan_last && ((ship_st && !fired_q) || bullet_st);
  assign sel_bullet  = bullet_st || to_bullet;
  assign scan_start  = accept || start_erase || to_bullet;

  assign org_x  = sel_bullet ? (x_l_q + 8'(SHIP_W / 2)) :
                  ((state_q == ST_READY) ? x_clamp : x_l_q);
  assign org_y  = sel_bullet ? 7'(SHIP_Y - 1) : 7'(SHIP_Y);
  assign scan_w = sel_bullet ? 8'd1 : 8'(SHIP_W);
  assign scan_h = sel_bullet ? 7'(BULLET_H) : 7'(SHIP_H);

  rect_scanner #(.XW(8), .YW(7)) u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (scan_start),
    .up      (sel_bullet),
    .org_x   (org_x),
    .org_y   (org_y),
    .width   (scan_w),
    .height  (scan_h),
    .px      (scan_px),
    .py      (scan_py),
    .valid   (scan_valid),
    .last    (scan_last)
  );

  always_comb begin
    state_d  = state_q;
    x_l_d    = x_l_q;
    fired_d  = fired_q;
    hold_d   = hold_q;
    colour_d = colour_q;
    done_d   = 1'b0;
    if (scan_start) colour_d = erase_ctx ? COL_BG : (sel_bullet ? COL_BULLET : COL_SHIP);
    case (state_q)
      ST_READY: if (accept) begin
        x_l_d   = x_clamp;
        fired_d = (op == OP_FIRE);
        state_d = ST_DRAW_SHIP;
      end
      ST_DRAW_SHIP, ST_DRAW_BULLET: begin
        if (to_bullet) state_d = ST_DRAW_BULLET;
        else if (seq_end) begin
          state_d = ST_HOLD;
          hold_d  = HW'(HOLD_CYCLES - 1);
          done_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_NEED_ERASE;
        else hold_d = hold_q - HW'(1);
      end
      ST_NEED_ERASE: if (start_erase) state_d = ST_ERASE_SHIP;
      ST_ERASE_SHIP, ST_ERASE_BULLET: begin
        if (to_bullet) state_d = ST_ERASE_BULLET;
        else if (seq_end) begin
          state_d = ST_READY;
          fired_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_READY;
      x_l_q    <= '0;
      fired_q  <= 1'b0;
      hold_q   <= '0;
      colour_q <= COL_BG;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_l_q    <= x_l_d;
      fired_q  <= fired_d;
      hold_q   <= hold_d;
      colour_q <= colour_d;
      done_q   <= done_d;
    end
  end

  assign self_state = state_code(state_q);
  assign vga_x      = scan_px;
  assign vga_y      = scan_py;
  assign vga_plot   = scan_valid;
  assign vga_colour = colour_q;
  assign done       = done_q;
endmodule

// File: doc/self_render.md
Name: self_render

Overview:
- Player-ship rendering engine: the datapath end of the player-control interface.
- Consumes `self_enable`/`op`/`x` from the player control FSM and reports `self_state` back to it.
- Draws, fire-draws or erases the ship sprite and bullet column as one-pixel-per-cycle writes to the VGA adapter.
- Paces the draw/erase loop with a per-frame hold timer.

Parameters:
- SCREEN_W, 160, screen width in pixels; the x range is 0..159.
- SHIP_W, 10, ship width in pixels.
- SHIP_H, 4, ship height in pixels.
- SHIP_Y, 110, top row of the ship.
- BULLET_H, 100, bullet column height; rows SHIP_Y-1 down to SHIP_Y-BULLET_H.
- HOLD_CYCLES, 833333, cycles the drawn image persists before an erase is requested (60 Hz at 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- self_enable  in  1  request strobe from control; may be held high continuously
- op  in  2  00 = draw ship, 10 = draw ship and fire bullet, 01 = erase, 11 = reserved
- x  in  8  requested ship left edge
- self_state  out  4  0 = BUSY, 1 = READY (accepts op 00/10), 2 = NEED_ERASE (accepts op 01)
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour: ship 3'b010, bullet 3'b100, background 3'b000
- vga_plot  out  1  pixel write strobe
- done  out  1  one-cycle pulse at the end of each draw or erase sequence

Behaviour:
- Reset: reset reset_n, synchronous, active-low; clock clk.
- Reset values: state READY, so `self_state`=1; `vga_plot`=0; `done`=0; `vga_x`=0, `vga_y`=0, `vga_colour`=0; fired flag=0; latched x=0.
- FSM states: READY, DRAW_SHIP, DRAW_BULLET, HOLD, NEED_ERASE, ERASE_SHIP, ERASE_BULLET.
- `self_state` encoding: READY→1, NEED_ERASE→2, every other state→0.
- READY:
  - On a cycle with `self_enable`=1 and `op`=00 or 10: latch x_l = min(x, SCREEN_W-SHIP_W), so 151..255 clamps to 150.
  - Also set fired = (`op`==10), then go to DRAW_SHIP.
  - `op`=01 or 11 is ignored.
- Single acceptance: the state leaves READY on the acceptance edge, so a continuously held `self_enable` cannot accept twice.
- DRAW_SHIP:
  - Raster scan, inner column cx 0..SHIP_W-1, outer row cy 0..SHIP_H-1.
  - Emits (x_l+cx, SHIP_Y+cy, ship colour) with `vga_plot`=1 on SHIP_W*SHIP_H consecutive cycles.
  - All pixel outputs are registered; the first pixel appears the cycle after acceptance.
  - On the last pixel: go to DRAW_BULLET if fired, else to HOLD.
- DRAW_BULLET:
  - BULLET_H pixels at column x_l+SHIP_W/2, rows SHIP_Y-1 down to SHIP_Y-BULLET_H, bullet colour.
  - Then go to HOLD.
- Draw-sequence end: `done` pulses on the cycle after the final pixel of the draw sequence.
- `vga_plot` is 0 in READY, HOLD and NEED_ERASE.
- HOLD:
  - Counter loaded with HOLD_CYCLES-1, decrements to 0.
  - Go to NEED_ERASE on 0; HOLD lasts exactly HOLD_CYCLES cycles.
- NEED_ERASE:
  - On `self_enable`=1 with `op`=01, go to ERASE_SHIP.
  - Any other op is ignored.
- ERASE_SHIP / ERASE_BULLET:
  - Same pixel sequence as the draw, at the latched x_l, in background colour.
  - ERASE_BULLET runs only if fired.
  - Then `done` pulses, fired clears, and the state returns to READY.
- Incoming `x` is ignored everywhere except on the READY acceptance edge; erase therefore always covers what was drawn.
- `self_enable` in BUSY states is ignored; there is no queueing.
- Reset mid-sequence: all state is cleared on that edge and `vga_plot` is 0 from the next cycle. A partially drawn sprite is left on screen; this is accepted.
- Widths:
  - Column/row counters are sized from the parameters.
  - x_l+cx never exceeds 159 because of the clamp.
  - SHIP_Y-BULLET_H ≥ 0 is required; an elaboration check enforces it.

Decomposition:
- Package `self_pkg`:
  - `self_state` codes (SELF_BUSY=0, SELF_READY=1, SELF_NEED_ERASE=2);
  - op codes (OP_DRAW=2'b00, OP_ERASE=2'b01, OP_FIRE=2'b10);
  - colour constants;
  - SCREEN_W.
- Sub-module `rect_scanner`:
  - Inputs: start, origin x/y, width, height.
  - Outputs: offset pixel coordinates, valid, last.
  - Reused for the ship rectangle and for the bullet column (width 1, scanned upward via a direction input).

Test Plan:
- Reset, then draw: `reset_n`=0 for 2 cycles → `self_state`=1, `vga_plot`=0. Then `self_enable`=1, `op`=00, `x`=82 → 40 consecutive plots, x 82..91, y 110..113, colour 010. Then `done`=1 for one cycle, `self_state`=0.
- Hold timing: with HOLD_CYCLES=20, `self_state` becomes 2 exactly 20 cycles after the draw `done` cycle. `op`=00 applied in that state is ignored.
- Fire: `op`=10, `x`=150 → 40 ship plots, then 100 bullet plots at x=155, y=109 down to 10, colour 100. Then op 01 → 140 background plots at the same coordinates, `self_state` returns to 1.
- Clamp and latch: `x`=250 → ship drawn at x 150..159. Changing `x` to 0 before erase → erase still at 150..159.
- Held enable: `self_enable` held high with `op`=00 across the whole cycle → exactly one 40-pixel draw per READY visit, no duplicate sequence.
- Reset mid-draw: assert `reset_n`=0 after pixel 17 → `vga_plot`=0 the next cycle, `self_state`=1 after release. A fresh `op`=00 restarts at pixel (x_l, 110).
